// File: rtl/wiegand_pkg.sv
// Shared types and helpers for the Wiegand-26 receiver.
// Parity rule: bit 25 even over 24:13, bit 0 odd over 12:1.
package wiegand_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    GAP,
    DONE,
    ERRW
  } wg_state_e;

  localparam int WG26_BITS = 26;

  function automatic logic wg26_parity_ok(input logic [25:0] f);
    return (~^f[25:13]) & (^f[12:0]);
  endfunction

endpackage

// File: rtl/wiegand_line_filter.sv
// Two-flop synchroniser for D0/D1 plus a per-line low-time qualifier.
// d0_ok/d1_ok assert once a line has been low GLITCH_CYC consecutive cycles.
module wiegand_line_filter #(
  parameter int GLITCH_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] wigend,
  output logic       d0_low,
  output logic       d1_low,
  output logic       both_low,
  output logic       d0_ok,
  output logic       d1_ok
);

  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam logic [GW-1:0] GLITCH_LOAD = GW'(GLITCH_CYC - 1);

  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [GW-1:0] cnt0;
  logic [GW-1:0] cnt1;

  // Synchroniser resets to idle-high so no phantom pulse follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 2'b11;
      sync <= 2'b11;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      meta <= wigend;
      sync <= meta;
      if (!d0_low)
        cnt0 <= GLITCH_LOAD;
      else if (cnt0 != '0)
        cnt0 <= cnt0 - 1'b1;
      if (!d1_low)
        cnt1 <= GLITCH_LOAD;
      else if (cnt1 != '0)
        cnt1 <= cnt1 - 1'b1;
    end
  end

  assign d0_low   = ~sync[0];
  assign d1_low   = ~sync[1];
  assign both_low = d0_low & d1_low;
  assign d0_ok    = d0_low && (cnt0 == '0);
  assign d1_ok    = d1_low && (cnt1 == '0);

endmodule

// File: rtl/wiegand_rx_frame.sv
// Wiegand-26 frame receiver: bit shifting, timeout framing, int/overrun.
// Build option WIEGAND_PARITY_CHECK_EN enables the 26-bit parity check at frame end.
module wiegand_rx_frame
  import wiegand_pkg::*;
#(
  parameter int FRAME_BITS  = WG26_BITS,
  parameter int GLITCH_CYC  = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int CNT_W       = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           wigend,
  output logic [WG26_BITS-1:0] data,
  output logic                 valid,
  output logic                 intr,
  input  logic                 int_ack,
  output logic                 overrun,
  output logic                 frame_err
);

  // state | meaning
  // IDLE  | no frame in progress, lines high
  // LOW   | one line low; qualifying or waiting for release
  // GAP   | between bits, timeout running
  // DONE  | frame end: accept or reject
  // ERRW  | both lines seen low; wait for both high

  localparam int BC_W = $clog2(FRAME_BITS + 2);
  localparam logic [BC_W-1:0]  BC_FULL  = BC_W'(FRAME_BITS);
  localparam logic [BC_W-1:0]  BC_SAT   = BC_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT_CYC - 1);

  wg_state_e             state;
  logic                  from_gap;
  logic                  taken;
  logic [CNT_W-1:0]      tmr;
  logic [BC_W-1:0]       bit_cnt;
  logic [WG26_BITS-1:0]  shift;
  logic                  par_ok;
  logic                  d0_low, d1_low, both_low, d0_ok, d1_ok;
  logic                  any_low;

  wiegand_line_filter #(
    .GLITCH_CYC(GLITCH_CYC)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .wigend  (wigend),
    .d0_low  (d0_low),
    .d1_low  (d1_low),
    .both_low(both_low),
    .d0_ok   (d0_ok),
    .d1_ok   (d1_ok)
  );

  assign any_low = d0_low | d1_low;

`ifdef WIEGAND_PARITY_CHECK_EN
  assign par_ok = wg26_parity_ok(shift);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      from_gap  <= 1'b0;
      taken     <= 1'b0;
      tmr       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      intr      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      // An ack landing in the valid cycle refers to the previous frame and is ignored.
      if (int_ack && !valid) begin
        intr    <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_low) begin
            state    <= LOW;
            from_gap <= 1'b0;
            taken    <= 1'b0;
          end
        end

        LOW: begin
          if (both_low) begin
            frame_err <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            state     <= ERRW;
          end else if (!taken) begin
            if (d1_ok || d0_ok) begin
              shift <= {shift[WG26_BITS-2:0], d1_ok};
              taken <= 1'b1;
              if (bit_cnt != BC_SAT)
                bit_cnt <= bit_cnt + 1'b1;
            end else if (!any_low) begin
              state <= from_gap ? GAP : IDLE;
              tmr   <= TMR_LOAD;
            end
          end else if (!any_low) begin
            state <= GAP;
            tmr   <= TMR_LOAD;
          end
        end

        GAP: begin
          if (both_low) begin
            frame_err <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            state     <= ERRW;
          end else if (any_low) begin
            state    <= LOW;
            from_gap <= 1'b1;
            taken    <= 1'b0;
          end else if (tmr == '0) begin
            state <= DONE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        DONE: begin
          if (bit_cnt == BC_FULL && par_ok) begin
            data  <= shift;
            valid <= 1'b1;
            intr  <= 1'b1;
            if (intr)
              overrun <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          shift   <= '0;
          bit_cnt <= '0;
          state   <= IDLE;
        end

        ERRW: begin
          if (!any_low)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wiegand_rx_frame.sv
// Directed bench for wiegand_rx_frame with an expected-event scoreboard.
module tb_wiegand_rx_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wigend;
  logic [25:0] data;
  logic        valid;
  logic        intr;
  logic        int_ack;
  logic        overrun;
  logic        frame_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_err;
    logic [25:0] frame;
  } exp_t;

  exp_t exp_q[$];

  logic [25:0] m_data = '0;
  logic        m_int  = 1'b0;
  logic        m_ovr  = 1'b0;

`ifdef WIEGAND_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  wiegand_rx_frame dut (
    .clk      (clk),
    .rst      (rst),
    .wigend   (wigend),
    .data     (data),
    .valid    (valid),
    .intr     (intr),
    .int_ack  (int_ack),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_parity(input logic [25:0] f);
    int ones_hi = 0;
    int ones_lo = 0;
    for (int i = 13; i <= 25; i++) ones_hi += int'(f[i]);
    for (int i = 0; i <= 12; i++) ones_lo += int'(f[i]);
    return (ones_hi % 2 == 0) && (ones_lo % 2 == 1);
  endfunction

  // Scoreboard consumer: every valid or frame_err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (valid || frame_err)) begin
      check(32'(exp_q.size() != 0), 32'd1, "sb_unexpected_event");
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(32'(frame_err), 32'(e.is_err), "sb_kind_err");
        check(32'(valid), 32'(!e.is_err), "sb_kind_valid");
        if (!e.is_err)
          check(32'(data), 32'(e.frame), "sb_data");
      end
    end
  end

  task automatic expect_frame(input logic [25:0] f, input int nbits);
    exp_t e;
    bit ok;
    ok = (nbits == 26) && (!PAR_EN || tb_parity(f));
    e.is_err = !ok;
    e.frame  = f;
    exp_q.push_back(e);
    if (ok) begin
      if (m_int) m_ovr = 1'b1;
      m_int  = 1'b1;
      m_data = f;
    end
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.frame  = '0;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input bit b, input int pw, input int gap);
    @(negedge clk);
    if (b) wigend = 2'b01; else wigend = 2'b10;
    repeat (pw) @(negedge clk);
    wigend = 2'b11;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bits(input logic [25:0] f, input int hi, input int lo, input int pw, input int gap);
    for (int i = hi; i >= lo; i--) send_bit(f[i], pw, gap);
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 7000) begin
      @(negedge clk);
      n++;
    end
    check(32'(exp_q.size()), 32'd0, tag);
  endtask

  task automatic ack();
    @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    m_int = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check(32'(data), 32'(m_data), {tag, "_data"});
    check(32'(intr), 32'(m_int), {tag, "_int"});
    check(32'(overrun), 32'(m_ovr), {tag, "_overrun"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst     = 1'b1;
    wigend  = 2'b11;
    int_ack = 1'b0;
    repeat (4) @(negedge clk);
    check(32'(data), 32'd0, "rst_data");
    check(32'(valid), 32'd0, "rst_valid");
    check(32'(intr), 32'd0, "rst_int");
    check(32'(overrun), 32'd0, "rst_overrun");
    check(32'(frame_err), 32'd0, "rst_frame_err");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame with long gaps
    expect_frame(26'h2AAAAAA, 26);
    send_bits(26'h2AAAAAA, 25, 0, 50, 1000);
    wait_sb("t1_drain");
    check_model("t1");

    // 25 bits only: rejected, previous data and int kept
    expect_frame(26'h0ABCDEF, 25);
    send_bits(26'h0ABCDEF, 24, 0, 10, 20);
    wait_sb("t2_drain");
    check_model("t2");
    ack();
    check_model("t2_ack");

    // Short D1 glitch between bits is dropped
    expect_frame(26'h155AA33, 26);
    send_bits(26'h155AA33, 25, 13, 10, 20);
    @(negedge clk);
    wigend = 2'b01;
    repeat (2) @(negedge clk);
    wigend = 2'b11;
    repeat (20) @(negedge clk);
    send_bits(26'h155AA33, 12, 0, 10, 20);
    wait_sb("t3_drain");
    check_model("t3");
    ack();

    // Both lines low mid-frame, then a clean frame
    expect_err();
    send_bits(26'h3FFFFFF, 25, 16, 10, 20);
    @(negedge clk);
    wigend = 2'b00;
    repeat (20) @(negedge clk);
    wigend = 2'b11;
    repeat (50) @(negedge clk);
    wait_sb("t4_err_drain");
    expect_frame(26'h3C0FFEE, 26);
    send_bits(26'h3C0FFEE, 25, 0, 10, 20);
    wait_sb("t4_drain");
    check_model("t4");

    // Second frame before ack, with ack landing in the valid cycle
    expect_frame(26'h1234567, 26);
    send_bits(26'h1234567, 25, 0, 10, 20);
    n = 0;
    while (!valid && n < 7000) begin
      @(negedge clk);
      n++;
    end
    check(32'(valid), 32'd1, "t5_valid_seen");
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    repeat (2) @(negedge clk);
    check(32'(exp_q.size()), 32'd0, "t5_drain");
    check_model("t5");
    ack();
    check_model("t5_ack");

    // Frame with a bad leading (even) parity bit
    expect_frame(26'h2000000, 26);
    send_bits(26'h2000000, 25, 0, 10, 20);
    wait_sb("t6_drain");
    check_model("t6");
    if (m_int) ack();

    // Reset mid-frame loses the partial frame
    send_bits(26'h3FFFFFF, 25, 16, 10, 20);
    @(negedge clk);
    rst = 1'b1;
    m_data = '0;
    m_int  = 1'b0;
    m_ovr  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_model("t7_rst");
    expect_frame(26'h0F0F0F0, 26);
    send_bits(26'h0F0F0F0, 25, 0, 10, 20);
    wait_sb("t7_drain");
    check_model("t7");

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
